modbus_tx_framer: RTL and testbench

Request-to-frame builder sitting directly upstream of the Modbus UART plugin's 72-bit `data_out` port. It accepts one request at a time: slave address, function code and two 16-bit words. It computes the Modbus RTU CRC-16 bit-serially and presents a complete 8-byte frame, with a length nibble, as a single-cycle pulse on `data_out`. It then tracks the transmitter's `tx_en` and enforces the RTU inter-frame silence before accepting the next request.

---
 rtl/modbus_pkg.sv | 27 ++
 rtl/modbus_crc16_serial.sv | 28 ++
 rtl/modbus_tx_framer.sv | 134 +++++++++++++
 tb/tb_modbus_tx_framer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/modbus_pkg.sv
// Shared types and constants for the Modbus RTU framing logic.
package modbus_pkg;

  localparam logic [15:0] MB_CRC_INIT  = 16'hFFFF;
  localparam logic [15:0] MB_CRC_POLY  = 16'hA001;
  localparam logic [3:0]  MB_FRAME_LEN = 4'd8;

  // Byte position of each field inside the transmitted frame
  localparam int unsigned MB_BYTE_ADDR     = 0;
  localparam int unsigned MB_BYTE_FUNC     = 1;
  localparam int unsigned MB_BYTE_WORD0_HI = 2;
  localparam int unsigned MB_BYTE_WORD0_LO = 3;
  localparam int unsigned MB_BYTE_WORD1_HI = 4;
  localparam int unsigned MB_BYTE_WORD1_LO = 5;
  localparam int unsigned MB_BYTE_CRC_LO   = 6;
  localparam int unsigned MB_BYTE_CRC_HI   = 7;

  typedef enum logic [2:0] {
    StIdle,
    StCrc,
    StEmit,
    StWaitBusy,
    StWaitDone,
    StGap
  } mb_state_e;

endpackage

// File: rtl/modbus_crc16_serial.sv
// Bit-serial CRC-16/MODBUS register, one message bit (LSB first) per enabled cycle.
module modbus_crc16_serial
  import modbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic        fb;

  assign fb  = crc_q[0] ^ bit_in;
  assign crc = crc_q;

  // Reflected LFSR step; init takes priority over a shift in the same cycle
  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc_q <= MB_CRC_INIT;
    end else if (en) begin
      crc_q <= (crc_q >> 1) ^ (fb ? MB_CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/modbus_tx_framer.sv
// Builds an 8-byte Modbus RTU frame from a request, emits it as a one-cycle
// pulse on data_out, then follows tx_en and enforces the inter-frame silence.
module modbus_tx_framer
  import modbus_pkg::*;
#(
  parameter int unsigned ClkFrequency = 12000000,
  parameter int unsigned Baud         = 9600,
  parameter int unsigned GapBits      = 39,
  parameter int unsigned BusyTimeout  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_func,
  input  logic [15:0] req_word0,
  input  logic [15:0] req_word1,
  output logic [71:0] data_out,
  input  logic        tx_en,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam int unsigned GapCycles = ClkFrequency / Baud * GapBits;
  localparam int unsigned GapW      = $clog2(GapCycles + 1);
  localparam int unsigned BusyW     = $clog2(BusyTimeout + 1);

  localparam logic [GapW-1:0]  GapLast  = GapW'(GapCycles - 1);
  localparam logic [BusyW-1:0] BusyLast = BusyW'(BusyTimeout - 1);

  mb_state_e        state_q;
  logic [47:0]      sr_q;
  logic [5:0]       bitcnt_q;
  logic [BusyW-1:0] busy_cnt_q;
  logic [GapW-1:0]  gap_cnt_q;
  logic [15:0]      crc;
  logic             accept;

  assign accept = req_valid && (state_q == StIdle);

  // The shift register rotates rather than shifts, so after 48 CRC cycles it
  // holds the original payload again, ready to be emitted.
  modbus_crc16_serial u_crc (
    .clk    (clk),
    .rst    (rst),
    .init   (accept),
    .en     (state_q == StCrc),
    .bit_in (sr_q[0]),
    .crc    (crc)
  );

  // Request FSM with payload register and the busy/gap counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      bitcnt_q   <= '0;
      busy_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            sr_q[8*MB_BYTE_ADDR     +: 8] <= req_addr;
            sr_q[8*MB_BYTE_FUNC     +: 8] <= req_func;
            sr_q[8*MB_BYTE_WORD0_HI +: 8] <= req_word0[15:8];
            sr_q[8*MB_BYTE_WORD0_LO +: 8] <= req_word0[7:0];
            sr_q[8*MB_BYTE_WORD1_HI +: 8] <= req_word1[15:8];
            sr_q[8*MB_BYTE_WORD1_LO +: 8] <= req_word1[7:0];
            bitcnt_q <= '0;
            state_q  <= StCrc;
          end
        end
        StCrc: begin
          sr_q     <= {sr_q[0], sr_q[47:1]};
          bitcnt_q <= bitcnt_q + 6'd1;
          if (bitcnt_q == 6'd47) begin
            state_q <= StEmit;
          end
        end
        StEmit: begin
          busy_cnt_q <= '0;
          state_q    <= StWaitBusy;
        end
        StWaitBusy: begin
          if (tx_en) begin
            state_q <= StWaitDone;
          end else if (busy_cnt_q == BusyLast) begin
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end else begin
            busy_cnt_q <= busy_cnt_q + BusyW'(1);
          end
        end
        StWaitDone: begin
          if (!tx_en) begin
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end
        end
        StGap: begin
          // Any line activity restarts the silence window
          if (tx_en) begin
            gap_cnt_q <= '0;
          end else if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StGap) && !tx_en && (gap_cnt_q == GapLast);
  assign timeout   = (state_q == StWaitBusy) && !tx_en && (busy_cnt_q == BusyLast);

  // Frame is non-zero only in EMIT, so the plugin sees a length of 0 otherwise
  always_comb begin
    data_out = '0;
    if (state_q == StEmit) begin
      data_out[3:0]                     = MB_FRAME_LEN;
      data_out[55:8]                    = sr_q;
      data_out[8+8*MB_BYTE_CRC_LO +: 8] = crc[7:0];
      data_out[8+8*MB_BYTE_CRC_HI +: 8] = crc[15:8];
    end
  end

endmodule

// File: tb/tb_modbus_tx_framer.sv
// Self-checking bench for modbus_tx_framer with a byte-level CRC reference.
module tb_modbus_tx_framer;

  localparam int unsigned CLK_HZ  = 96000;
  localparam int unsigned BAUD    = 9600;
  localparam int unsigned GAPBITS = 3;
  localparam int unsigned BUSY_TO = 16;
  localparam int          GAP     = CLK_HZ / BAUD * GAPBITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = '0;
  logic [7:0]  req_func = '0;
  logic [15:0] req_word0 = '0;
  logic [15:0] req_word1 = '0;
  logic [71:0] data_out;
  logic        tx_en = 1'b0;
  logic        busy;
  logic        done;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int glitch_at = -1;

  modbus_tx_framer #(
    .ClkFrequency (CLK_HZ),
    .Baud         (BAUD),
    .GapBits      (GAPBITS),
    .BusyTimeout  (BUSY_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_func  (req_func),
    .req_word0 (req_word0),
    .req_word1 (req_word1),
    .data_out  (data_out),
    .tx_en     (tx_en),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Standard byte-wise CRC-16/MODBUS over the six payload bytes
  function automatic logic [15:0] crc_model(input logic [7:0] b [8]);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < 6; k++) begin
      c = c ^ {8'h00, b[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [71:0] frame_model(input logic [7:0] a, f, input logic [15:0] w0, w1);
    logic [7:0]  b [8];
    logic [15:0] c;
    logic [71:0] fr;
    b[0] = a; b[1] = f; b[2] = w0[15:8]; b[3] = w0[7:0]; b[4] = w1[15:8]; b[5] = w1[7:0];
    b[6] = 8'h00; b[7] = 8'h00;
    c = crc_model(b);
    b[6] = c[7:0]; b[7] = c[15:8];
    fr = '0;
    fr[3:0] = 4'd8;
    for (int n = 0; n < 8; n++) fr[8+8*n +: 8] = b[n];
    return fr;
  endfunction

  // Advance one cycle; tx_en is high in [lo,hi) and at glitch_at
  task automatic tick(input int lo, input int hi);
    @(posedge clk);
    #1;
    tx_en = ((cyc >= lo) && (cyc < hi)) || (cyc == glitch_at);
    #1;
  endtask

  // Present a request, return accept cycle, emit cycle and the emitted frame
  task automatic run_frame(input logic [7:0] a, f, input logic [15:0] w0, w1,
                           output int t, output int e, output logic [71:0] fr);
    req_valid = 1'b1; req_addr = a; req_func = f; req_word0 = w0; req_word1 = w1;
    t = -1; e = -1; fr = '0;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin t = cyc; break; end
      tick(0, 0);
    end
    tick(0, 0);
    req_valid = 1'b0;
    req_addr = 8'($urandom); req_func = 8'($urandom);
    req_word0 = 16'($urandom); req_word1 = 16'($urandom);
    for (int i = 0; i < 60; i++) begin
      if (data_out !== 72'h0) begin e = cyc; fr = data_out; break; end
      tick(0, 0);
    end
  endtask

  // Let the current transaction finish with a short transmit burst
  task automatic drain(output bit ok);
    int s;
    s = cyc;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(s + 2, s + 4);
      if (req_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(0, 0); tick(0, 0); tick(0, 0);
    rst = 1'b0;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
    n_tests++; if (data_out !== 72'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_out); end
  endtask

  task automatic test_spec_vector();
    int t, e; logic [71:0] fr; bit ok;
    run_frame(8'h11, 8'h03, 16'h006B, 16'h0003, t, e, fr);
    n_tests++; if (e - t !== 49) begin n_fail++; $display("FAIL spec_latency got %0d want 49", e - t); end
    n_tests++;
    if (fr !== 72'h87_76_03_00_6B_00_03_11_08) begin
      n_fail++; $display("FAIL spec_frame got %h want 877603006b00031108", fr);
    end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL spec_busy got %b want 1", busy); end
    tick(0, 0);
    n_tests++; if (data_out !== 72'h0) begin n_fail++; $display("FAIL spec_after got %h want 0", data_out); end
    drain(ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL spec_drain got %b want 1", ok); end
  endtask

  task automatic test_read_request();
    int t, e; logic [71:0] fr; bit ok;
    run_frame(8'h01, 8'h03, 16'h0000, 16'h0001, t, e, fr);
    n_tests++; if (e - t !== 49) begin n_fail++; $display("FAIL read_latency got %0d want 49", e - t); end
    n_tests++;
    if (fr !== 72'h0A_84_01_00_00_00_03_01_08) begin
      n_fail++; $display("FAIL read_frame got %h want 0a8401000000030108", fr);
    end
    drain(ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL read_drain got %b want 1", ok); end
  endtask

  task automatic test_handshake();
    int t, e, t2, e2, dc; logic [71:0] fr, fr2; bit early, ok;
    logic [7:0] a, f; logic [15:0] w0, w1;
    a = 8'($urandom); f = 8'($urandom); w0 = 16'($urandom); w1 = 16'($urandom);
    run_frame(8'h0A, 8'h06, 16'h1234, 16'hBEEF, t, e, fr);
    n_tests++;
    if (fr !== frame_model(8'h0A, 8'h06, 16'h1234, 16'hBEEF)) begin
      n_fail++; $display("FAIL hs_frame1 got %h want %h", fr, frame_model(8'h0A, 8'h06, 16'h1234, 16'hBEEF));
    end
    req_valid = 1'b1; req_addr = a; req_func = f; req_word0 = w0; req_word1 = w1;
    dc = -1; early = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(e + 3, e + 103);
      if (req_ready) early = 1'b1;
      if (done) begin dc = cyc; break; end
    end
    n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL hs_early_ready got %b want 0", early); end
    n_tests++; if (dc !== e + 103 + GAP) begin n_fail++; $display("FAIL hs_done got %0d want %0d", dc, e + 103 + GAP); end
    tick(0, 0);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL hs_ready_after got %b want 1", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_busy_after got %b want 0", busy); end
    run_frame(a, f, w0, w1, t2, e2, fr2);
    n_tests++; if (t2 !== dc + 1) begin n_fail++; $display("FAIL hs_accept2 got %0d want %0d", t2, dc + 1); end
    n_tests++; if (fr2 !== frame_model(a, f, w0, w1)) begin
      n_fail++; $display("FAIL hs_frame2 got %h want %h", fr2, frame_model(a, f, w0, w1));
    end
    drain(ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hs_drain got %b want 1", ok); end
  endtask

  task automatic test_timeout();
    int t, e, tc, tn, dc; logic [71:0] fr;
    run_frame(8'($urandom), 8'h03, 16'($urandom), 16'($urandom), t, e, fr);
    tc = -1; tn = 0; dc = -1;
    for (int i = 0; i < 300; i++) begin
      tick(0, 0);
      if (timeout) begin tn++; if (tc < 0) tc = cyc; end
      if (done) begin dc = cyc; break; end
    end
    n_tests++; if (tc !== e + BUSY_TO) begin n_fail++; $display("FAIL to_cycle got %0d want %0d", tc, e + BUSY_TO); end
    n_tests++; if (tn !== 1) begin n_fail++; $display("FAIL to_pulses got %0d want 1", tn); end
    n_tests++; if (dc !== e + BUSY_TO + GAP) begin
      n_fail++; $display("FAIL to_done got %0d want %0d", dc, e + BUSY_TO + GAP);
    end
    tick(0, 0);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL to_idle got %b want 1", req_ready); end
  endtask

  task automatic test_gap_glitch();
    int t, e, dc, exp_dc; logic [71:0] fr;
    run_frame(8'($urandom), 8'h10, 16'($urandom), 16'($urandom), t, e, fr);
    // tx_en falls at e+6 so silence starts at e+7; glitch lands inside it
    glitch_at = e + 7 + int'($urandom_range(0, GAP - 2));
    exp_dc = glitch_at + GAP;
    dc = -1;
    for (int i = 0; i < 300; i++) begin
      tick(e + 2, e + 6);
      if (done) begin dc = cyc; break; end
    end
    glitch_at = -1;
    n_tests++; if (dc !== exp_dc) begin n_fail++; $display("FAIL glitch_done got %0d want %0d", dc, exp_dc); end
    tick(0, 0);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL glitch_idle got %b want 1", req_ready); end
  endtask

  task automatic test_reset_mid_crc();
    int t, e, t0; logic [71:0] fr; bit ok;
    logic [7:0] a, f; logic [15:0] w0, w1;
    req_valid = 1'b1; req_addr = 8'h55; req_func = 8'h03; req_word0 = 16'hAAAA; req_word1 = 16'h5555;
    t0 = cyc;
    tick(0, 0);
    req_valid = 1'b0;
    while (cyc < t0 + 21) tick(0, 0);
    rst = 1'b1;
    tick(0, 0);
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstcrc_busy got %b want 0", busy); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstcrc_ready got %b want 1", req_ready); end
    n_tests++; if (data_out !== 72'h0) begin n_fail++; $display("FAIL rstcrc_data got %h want 0", data_out); end
    a = 8'($urandom); f = 8'($urandom); w0 = 16'($urandom); w1 = 16'($urandom);
    run_frame(a, f, w0, w1, t, e, fr);
    n_tests++; if (fr !== frame_model(a, f, w0, w1)) begin
      n_fail++; $display("FAIL rstcrc_frame got %h want %h", fr, frame_model(a, f, w0, w1));
    end
    drain(ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rstcrc_drain got %b want 1", ok); end
  endtask

  task automatic test_random();
    int t, e; logic [71:0] fr; bit ok;
    logic [7:0] a, f; logic [15:0] w0, w1;
    for (int k = 0; k < 6; k++) begin
      a = 8'($urandom); f = 8'($urandom); w0 = 16'($urandom); w1 = 16'($urandom);
      run_frame(a, f, w0, w1, t, e, fr);
      n_tests++; if (e - t !== 49) begin n_fail++; $display("FAIL rand_latency[%0d] got %0d want 49", k, e - t); end
      n_tests++; if (fr !== frame_model(a, f, w0, w1)) begin
        n_fail++; $display("FAIL rand_frame[%0d] got %h want %h", k, fr, frame_model(a, f, w0, w1));
      end
      drain(ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_drain[%0d] got %b want 1", k, ok); end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_read_request();
    test_handshake();
    test_timeout();
    test_gap_glitch();
    test_reset_mid_crc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
